// File: rtl/dmem_arbiter_if.sv
// Bus between the two requesters, the data memory and the arbiter.
// Master is the environment (CPU, loader, memory); slave is the arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] D_addr;
    logic          D_rd, D_wr;
    logic [DW-1:0] W_data, R_data;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, R_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  D_addr, D_rd, D_wr, W_data
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, R_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output D_addr, D_rd, D_wr, W_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU (port 0)
// and the loader (port 1); one transaction at a time, 1-cycle registered reads.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus,
    output logic                busy,
    output logic [7:0]          contention_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [1:0]    state;
    logic          last_grant;
    logic          cmd_id;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic tie;
    logic any_req;
    logic winner;
    logic issue;
    logic rdata_phase;
    logic rvalid0;
    logic rvalid1;

    assign tie     = bus.req0 && bus.req1;
    assign any_req = bus.req0 || bus.req1;

    // NOTE: winner gets its default before the conditional override, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = bus.req1 && !bus.req0;
        if (tie) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : !last_grant;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            cmd_id         <= 1'b0;
            cmd_we         <= 1'b0;
            cmd_addr       <= '0;
            cmd_wdata      <= '0;
            contention_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ISSUE;
                        cmd_id     <= winner;
                        last_grant <= winner;
                        cmd_we     <= winner ? bus.we1    : bus.we0;
                        cmd_addr   <= winner ? bus.addr1  : bus.addr0;
                        cmd_wdata  <= winner ? bus.wdata1 : bus.wdata0;
                    end
                end
                ISSUE:   state <= cmd_we ? IDLE : RDATA;
                RDATA:   state <= IDLE;
                default: state <= IDLE;
            endcase

            if (state == IDLE && tie && contention_cnt != 8'hFF) begin
                contention_cnt <= contention_cnt + 8'd1;
            end
        end
    end

    // Strobes, grants and valids are qualified with rst so an in-flight
    // transaction is silently dropped in the cycle reset is applied.
    assign issue       = (state == ISSUE) && rst;
    assign rdata_phase = (state == RDATA) && rst;
    assign rvalid0     = rdata_phase && !cmd_id;
    assign rvalid1     = rdata_phase && cmd_id;

    assign bus.gnt0    = issue && !cmd_id;
    assign bus.gnt1    = issue && cmd_id;
    assign bus.D_wr    = issue && cmd_we;
    assign bus.D_rd    = issue && !cmd_we;
    assign bus.D_addr  = (state == ISSUE) ? cmd_addr  : '0;
    assign bus.W_data  = (state == ISSUE) ? cmd_wdata : '0;

    assign bus.rvalid0 = rvalid0;
    assign bus.rvalid1 = rvalid1;
    assign bus.rdata0  = rvalid0 ? bus.R_data : '0;
    assign bus.rdata1  = rvalid1 ? bus.R_data : '0;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share one
// directed stimulus, each checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0]    gnt0_v, gnt1_v, rv0_v, rv1_v, drd_v, dwr_v, busy_v;
    logic [AW-1:0] daddr_v [2];
    logic [DW-1:0] wdat_v  [2];
    logic [DW-1:0] rd0_v   [2];
    logic [DW-1:0] rd1_v   [2];
    logic [7:0]    cnt_v   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: round-robin; instance 1: fixed priority. Each has its own memory.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        bit [DW-1:0] mem [256];
        logic        busy;
        logic [7:0]  cnt;

        dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(g)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .bus            (bus),
            .busy           (busy),
            .contention_cnt (cnt)
        );

        assign bus.req0   = req0;
        assign bus.req1   = req1;
        assign bus.we0    = we0;
        assign bus.we1    = we1;
        assign bus.addr0  = addr0;
        assign bus.addr1  = addr1;
        assign bus.wdata0 = wdata0;
        assign bus.wdata1 = wdata1;

        always @(posedge clk) begin
            if (bus.D_wr) mem[bus.D_addr] <= bus.W_data;
            if (bus.D_rd) bus.R_data <= mem[bus.D_addr];
        end

        assign gnt0_v[g]  = bus.gnt0;
        assign gnt1_v[g]  = bus.gnt1;
        assign rv0_v[g]   = bus.rvalid0;
        assign rv1_v[g]   = bus.rvalid1;
        assign drd_v[g]   = bus.D_rd;
        assign dwr_v[g]   = bus.D_wr;
        assign busy_v[g]  = busy;
        assign daddr_v[g] = bus.D_addr;
        assign wdat_v[g]  = bus.W_data;
        assign rd0_v[g]   = bus.rdata0;
        assign rd1_v[g]   = bus.rdata1;
        assign cnt_v[g]   = cnt;
    end

    task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_bit(string name, int inst, logic act, logic exp);
        check(name, inst, 32'(act), 32'(exp));
    endtask

    // Transaction model: an accepted command occupies the cycle after acceptance
    // (issue) and, for reads, one more (data return). now = current cycle index.
    int          now = 0;
    bit          m_active [2];
    int          m_t0     [2];
    bit          m_last   [2] = '{1'b1, 1'b1};
    int          m_cnt    [2];
    txn_t        mt       [2];
    bit [DW-1:0] mmem     [2][256];

    function automatic bit in_issue(int i);
        return m_active[i] && (now == m_t0[i] + 1);
    endfunction

    function automatic bit in_rdata(int i);
        return m_active[i] && !mt[i].we && (now == m_t0[i] + 2);
    endfunction

    function automatic bit pick(int i);
        if (req0 && req1) return (i == 1) ? 1'b0 : !m_last[i];
        return !req0;
    endfunction

    function automatic txn_t cmd_of(bit p);
        txn_t t;
        t.id    = p;
        t.we    = p ? we1    : we0;
        t.addr  = p ? addr1  : addr0;
        t.wdata = p ? wdata1 : wdata0;
        return t;
    endfunction

    always @(posedge clk) begin
        now <= now + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst && in_issue(i) && mt[i].we) mmem[i][mt[i].addr] <= mt[i].wdata;
            if (!rst) begin
                m_active[i] <= 1'b0;
                m_last[i]   <= 1'b1;
                m_cnt[i]    <= 0;
            end else if (!(in_issue(i) || in_rdata(i)) && (req0 || req1)) begin
                m_active[i] <= 1'b1;
                m_t0[i]     <= now;
                m_last[i]   <= pick(i);
                mt[i]       <= cmd_of(pick(i));
                if (req0 && req1) m_cnt[i] <= (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        if (now > 0) begin
            for (int i = 0; i < 2; i++) begin
                check_bit("gnt0",    i, gnt0_v[i], in_issue(i) && rst && !mt[i].id);
                check_bit("gnt1",    i, gnt1_v[i], in_issue(i) && rst && mt[i].id);
                check_bit("D_wr",    i, dwr_v[i],  in_issue(i) && rst && mt[i].we);
                check_bit("D_rd",    i, drd_v[i],  in_issue(i) && rst && !mt[i].we);
                check("D_addr",      i, 32'(daddr_v[i]), in_issue(i) ? 32'(mt[i].addr)  : 32'h0);
                check("W_data",      i, 32'(wdat_v[i]),  in_issue(i) ? 32'(mt[i].wdata) : 32'h0);
                check_bit("rvalid0", i, rv0_v[i],  in_rdata(i) && rst && !mt[i].id);
                check_bit("rvalid1", i, rv1_v[i],  in_rdata(i) && rst && mt[i].id);
                check("rdata0",      i, 32'(rd0_v[i]),
                      (in_rdata(i) && rst && !mt[i].id) ? 32'(mmem[i][mt[i].addr]) : 32'h0);
                check("rdata1",      i, 32'(rd1_v[i]),
                      (in_rdata(i) && rst && mt[i].id) ? 32'(mmem[i][mt[i].addr]) : 32'h0);
                check_bit("busy",    i, busy_v[i], in_issue(i) || in_rdata(i));
                check("cnt",         i, 32'(cnt_v[i]), 32'(m_cnt[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst = 0;
        tick();
        tick();
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_reset_busy", i, busy_v[i], 1'b0);
            check("lit_reset_cnt", i, 32'(cnt_v[i]), 32'h0);
        end

        // Single write on port 0
        tick();
        req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 16'hBEEF;
        tick();
        req0 = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_wr_gnt0", i, gnt0_v[i], 1'b1);
            check_bit("lit_wr_Dwr",  i, dwr_v[i],  1'b1);
            check("lit_wr_addr",     i, 32'(daddr_v[i]), 32'h12);
            check("lit_wr_wdata",    i, 32'(wdat_v[i]),  32'hBEEF);
        end
        tick();
        #1;
        for (int i = 0; i < 2; i++) check_bit("lit_wr_busy", i, busy_v[i], 1'b0);

        // Single read on port 1 of the word just written
        req1 = 1; we1 = 0; addr1 = 8'h12;
        tick();
        req1 = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_rd_gnt1", i, gnt1_v[i], 1'b1);
            check_bit("lit_rd_Drd",  i, drd_v[i],  1'b1);
        end
        tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_rd_rvalid1", i, rv1_v[i], 1'b1);
            check("lit_rd_rdata1",      i, 32'(rd1_v[i]), 32'hBEEF);
            check_bit("lit_rd_rvalid0", i, rv0_v[i], 1'b0);
        end
        tick();

        // Ties held until granted: round-robin alternates 0, 1, 0
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 8'h21; wdata1 = 16'h2222;
        tick();
        #1;
        check_bit("lit_rr_first_gnt0", 0, gnt0_v[0], 1'b1);
        for (int i = 0; i < 2; i++) check("lit_tie_cnt1", i, 32'(cnt_v[i]), 32'h1);
        tick();
        addr0 = 8'h22; wdata0 = 16'h3333;
        tick();
        #1;
        check_bit("lit_rr_second_gnt1", 0, gnt1_v[0], 1'b1);
        check_bit("lit_rr_second_gnt0", 0, gnt0_v[0], 1'b0);
        req1 = 0;
        tick();
        tick();
        #1;
        check_bit("lit_rr_third_gnt0", 0, gnt0_v[0], 1'b1);
        check("lit_rr_third_addr", 0, 32'(daddr_v[0]), 32'h22);
        req0 = 0;
        tick();
        #1;
        for (int i = 0; i < 2; i++) check("lit_tie_cnt2", i, 32'(cnt_v[i]), 32'h2);

        // Ties held repeatedly: fixed priority keeps granting port 0
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 16'hAAAA;
        req1 = 1; we1 = 1; addr1 = 8'h41; wdata1 = 16'h5555;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) req0 = 0;
            #1;
            if (k % 2 == 1) begin
                check_bit("lit_fp_gnt0", 1, gnt0_v[1], 1'b1);
                check_bit("lit_fp_gnt1", 1, gnt1_v[1], 1'b0);
            end
        end
        tick();
        #1;
        check_bit("lit_fp_late_gnt1", 1, gnt1_v[1], 1'b1);
        req1 = 0;
        tick();

        // Reset during the issue cycle of a write
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 16'h5A5A;
        req1 = 1; we1 = 1; addr1 = 8'h31; wdata1 = 16'hA5A5;
        tick();
        rst = 0; req0 = 0; req1 = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_rst_Dwr",  i, dwr_v[i],  1'b0);
            check_bit("lit_rst_gnt0", i, gnt0_v[i], 1'b0);
            check_bit("lit_rst_gnt1", i, gnt1_v[i], 1'b0);
        end
        tick();
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_rst_busy", i, busy_v[i], 1'b0);
            check("lit_rst_cnt",      i, 32'(cnt_v[i]), 32'h0);
            check_bit("lit_rst_nognt", i, gnt0_v[i] | gnt1_v[i], 1'b0);
        end
        // The abandoned write must not have reached memory
        req0 = 1; we0 = 0; addr0 = 8'h30;
        tick();
        req0 = 0;
        #1;
        for (int i = 0; i < 2; i++) check_bit("lit_rb_gnt0", i, gnt0_v[i], 1'b1);
        tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_bit("lit_rb_rvalid0", i, rv0_v[i], 1'b1);
            check("lit_rb_rdata0",      i, 32'(rd0_v[i]), 32'h0);
        end
        tick();

        // Saturation: 600 held cycles give 300 tie arbitrations
        req0 = 1; we0 = 1; addr0 = 8'h50; wdata0 = 16'h0F0F;
        req1 = 1; we1 = 1; addr1 = 8'h51; wdata1 = 16'hF0F0;
        repeat (600) tick();
        #1;
        for (int i = 0; i < 2; i++) check("lit_sat_cnt", i, 32'(cnt_v[i]), 32'd255);
        req0 = 0; req1 = 0;
        tick();
        tick();
        #1;
        for (int i = 0; i < 2; i++) check("lit_sat_hold", i, 32'(cnt_v[i]), 32'd255);

        // Tied reads held for a while, checked by the model only
        req0 = 1; we0 = 0; addr0 = 8'h20;
        req1 = 1; we1 = 0; addr1 = 8'h21;
        repeat (7) tick();
        req0 = 0; req1 = 0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
